// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: opcode encodings, FSM states, result flag bundle
// and the helper that tells which opcodes go through the iterative unit.
package seq_alu_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_OR  = 4'h1;
   localparam logic [3:0] OP_XOR = 4'h2;
   localparam logic [3:0] OP_NOT = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_MUL = 4'h6;
   localparam logic [3:0] OP_DIV = 4'h7;
   localparam logic [3:0] OP_REM = 4'h8;
   localparam logic [3:0] OP_SHL = 4'h9;
   localparam logic [3:0] OP_SHR = 4'hA;
   localparam logic [3:0] OP_SAR = 4'hB;
   localparam logic [3:0] OP_ROL = 4'hC;
   localparam logic [3:0] OP_ROR = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic div_by_zero;
   } flags_t;

   function automatic logic op_is_multi(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply / divide unit, one bit per cycle on magnitudes.
// Ports:
//   clock, clear_n : clock and synchronous active-low reset (aborts any op)
//   start          : load operands and perform the first iteration
//   mul            : 1 = multiply, 0 = divide (quotient + remainder)
//   a, b           : signed operands, sampled on start
//   done           : all WIDTH iterations complete; hi/lo valid
//   hi, lo         : MUL {high, low} product, DIV {remainder, quotient}
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             mul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]      cnt;
   logic               run, is_mul, neg, rem_neg;
   logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
   logic [WIDTH-1:0]   ld_mcand, ld_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // One iteration. MUL: shift-add, low half holds the remaining multiplier
   // bits. DIV: restoring step, low half shifts dividend out / quotient in.
   function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] h,
                                                input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] m,
                                                input logic             mul_f);
      logic [WIDTH:0]   sum, trial;
      logic [WIDTH-1:0] shifted;
      sum     = {1'b0, h} + (l[0] ? {1'b0, m} : '0);
      // remainder is always below the divisor (<= 2^(WIDTH-1)), so no bit is lost
      shifted = {h[WIDTH-2:0], l[WIDTH-1]};
      trial   = {1'b0, shifted} - {1'b0, m};
      if (mul_f)
         return {sum[WIDTH:1], sum[0], l[WIDTH-1:1]};
      else if (!trial[WIDTH])
         return {trial[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
      else
         return {shifted, l[WIDTH-2:0], 1'b0};
   endfunction

   assign ld_mcand = mul ? mag(a) : mag(b);
   assign ld_lo    = mul ? mag(b) : mag(a);

   // The load cycle already performs iteration 1, so the count reaches WIDTH
   // one cycle earlier and the FSM sees done in time for WIDTH+1 latency.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         run     <= 1'b0;
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         mcand   <= '0;
         is_mul  <= 1'b0;
         neg     <= 1'b0;
         rem_neg <= 1'b0;
      end else if (start) begin
         run              <= 1'b1;
         cnt              <= CW'(1);
         is_mul           <= mul;
         mcand            <= ld_mcand;
         neg              <= a[WIDTH-1] ^ b[WIDTH-1];
         rem_neg          <= a[WIDTH-1];
         {acc_hi, acc_lo} <= step('0, ld_lo, ld_mcand, mul);
      end else if (run && (cnt != CW'(WIDTH))) begin
         cnt              <= cnt + CW'(1);
         {acc_hi, acc_lo} <= step(acc_hi, acc_lo, mcand, is_mul);
      end
   end

   assign done     = run & (cnt == CW'(WIDTH));
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg ? -prod : prod;
   // quotient truncates toward zero, remainder follows the dividend's sign
   assign hi = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : (rem_neg ? -acc_hi : acc_hi);
   assign lo = is_mul ? prod_fix[WIDTH-1:0]       : (neg ? -acc_lo : acc_lo);

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU between register-read and writeback.
// Single-cycle logic/arith/shift/rotate ops, iterative signed MUL/DIV/REM.
// Ports:
//   clock, clear_n          : clock, synchronous active-low reset
//   in_valid/in_ready       : request handshake; opcode, a, b captured on accept
//   out_valid/out_ready     : result handshake; outputs held while stalled
//   result_lo/result_hi     : result, MUL product halves, DIV quotient/remainder
//   carry_out, overflow,
//   zero, div_by_zero       : registered status flags
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             div_by_zero
);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state;
   logic             accept, is_div, div_zero, md_start, md_done, div_ovf;
   logic [WIDTH-1:0] md_hi, md_lo, sc_lo, sc_hi;
   logic             sc_legal;
   flags_t           sc_flags;
   logic [WIDTH:0]   add_sum, sub_sum;
   logic [SHW-1:0]   sh;
   logic [SHW:0]     rsh;

   assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign is_div   = (opcode == OP_DIV) | (opcode == OP_REM);
   assign div_zero = is_div & (b == '0);
   // divide-by-zero is answered directly and never enters the iterative unit
   assign md_start = accept & op_is_multi(opcode) & ~div_zero;

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clock   (clock),
      .clear_n (clear_n),
      .start   (md_start),
      .mul     (opcode == OP_MUL),
      .a       (a),
      .b       (b),
      .done    (md_done),
      .hi      (md_hi),
      .lo      (md_lo)
   );

   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign sh      = b[SHW-1:0];
   // complementary rotate amount; sh==0 gives WIDTH, which shifts to zero
   assign rsh     = (SHW+1)'(WIDTH) - {1'b0, sh};

   always_comb begin
      sc_lo    = '0;
      sc_hi    = '0;
      sc_flags = '0;
      sc_legal = 1'b1;
      case (opcode)
         OP_AND: sc_lo = a & b;
         OP_OR:  sc_lo = a | b;
         OP_XOR: sc_lo = a ^ b;
         OP_NOT: sc_lo = ~a;
         OP_ADD: begin
            sc_lo             = add_sum[WIDTH-1:0];
            sc_flags.carry    = add_sum[WIDTH];
            sc_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_lo             = sub_sum[WIDTH-1:0];
            sc_flags.carry    = sub_sum[WIDTH];
            sc_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) & (sub_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_DIV, OP_REM: begin
            // only reaches the output registers for b==0
            sc_lo                = '1;
            sc_hi                = a;
            sc_flags.div_by_zero = 1'b1;
         end
         OP_MUL: sc_lo = '0;
         OP_SHL: sc_lo = a << sh;
         OP_SHR: sc_lo = a >> sh;
         OP_SAR: sc_lo = $unsigned($signed(a) >>> sh);
         OP_ROL: sc_lo = (a << sh) | (a >> rsh);
         OP_ROR: sc_lo = (a >> sh) | (a << rsh);
         default: sc_legal = 1'b0;
      endcase
      // illegal opcodes raise no flag at all, zero included
      sc_flags.zero = sc_legal & ~|{sc_hi, sc_lo};
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state       <= ST_IDLE;
         out_valid   <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         carry_out   <= 1'b0;
         overflow    <= 1'b0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
         div_ovf     <= 1'b0;
      end else begin
         case (state)
            ST_BUSY: begin
               if (md_done) begin
                  state       <= ST_DONE;
                  out_valid   <= 1'b1;
                  result_lo   <= md_lo;
                  result_hi   <= md_hi;
                  carry_out   <= 1'b0;
                  overflow    <= div_ovf;
                  zero        <= ~|{md_hi, md_lo};
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               if ((state == ST_DONE) && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
               // a new accept overrides the drain above (back-to-back)
               if (accept) begin
                  if (md_start) begin
                     state     <= ST_BUSY;
                     out_valid <= 1'b0;
                     // MIN / -1 is computed normally; only the flag is forced
                     div_ovf   <= is_div & (a == MIN_VAL) & (b == '1);
                  end else begin
                     state       <= ST_DONE;
                     out_valid   <= 1'b1;
                     result_lo   <= sc_lo;
                     result_hi   <= sc_hi;
                     carry_out   <= sc_flags.carry;
                     overflow    <= sc_flags.overflow;
                     zero        <= sc_flags.zero;
                     div_by_zero <= sc_flags.div_by_zero;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         clear_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   opcode = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, carry_out, overflow, zero, div_by_zero;
   logic [W-1:0] result_lo, result_hi;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         c;
      logic         o;
      logic         z;
      logic         d;
   } res_t;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   res_t sb_q[$];
   res_t obs;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   seq_alu #(.WIDTH(W)) dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .carry_out   (carry_out),
      .overflow    (overflow),
      .zero        (zero),
      .div_by_zero (div_by_zero)
   );

   assign obs = {result_hi, result_lo, carry_out, overflow, zero, div_by_zero};

   // Reference model built on native 64-bit arithmetic and bit loops.
   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t         r;
      longint       sx, sy, t, rm;
      logic [63:0]  p;
      logic [W-1:0] v;
      int           sh;
      bit           legal;
      r = '0; legal = 1'b1;
      sx = longint'($signed(x)); sy = longint'($signed(y));
      sh = int'(y[4:0]); v = x;
      case (op)
         4'h0: r.lo = x & y;
         4'h1: r.lo = x | y;
         4'h2: r.lo = x ^ y;
         4'h3: r.lo = ~x;
         4'h4: begin
            t = sx + sy; r.lo = x + y;
            r.c = (longint'({32'b0, x}) + longint'({32'b0, y})) >= 64'sh1_0000_0000;
            r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'h5: begin
            t = sx - sy; r.lo = x - y;
            r.c = (x >= y);
            r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'h6: begin
            t = sx * sy; p = t;
            r.hi = p[63:32]; r.lo = p[31:0];
         end
         4'h7, 4'h8: begin
            if (y == '0) begin
               r.lo = '1; r.hi = x; r.d = 1'b1;
            end else begin
               t = sx / sy; rm = sx % sy; p = t;
               r.lo = p[31:0]; p = rm; r.hi = p[31:0];
               r.o = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
            end
         end
         4'h9: r.lo = x << sh;
         4'hA: r.lo = x >> sh;
         4'hB: begin repeat (sh) v = {v[31], v[31:1]}; r.lo = v; end
         4'hC: begin repeat (sh) v = {v[30:0], v[31]}; r.lo = v; end
         4'hD: begin repeat (sh) v = {v[0], v[31:1]}; r.lo = v; end
         default: legal = 1'b0;
      endcase
      r.z = legal && ({r.hi, r.lo} == '0);
      return r;
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] y);
      if (op == 4'h6 || ((op == 4'h7 || op == 4'h8) && y != '0)) return W + 1;
      return 1;
   endfunction

   // Drive a request and hold it until accepted; returns 1 time unit after
   // the accepting edge. Inputs are scrambled afterwards to show capture.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
      int n = 0;
      opcode = op; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL issue_timeout op=%h in_ready=%b required=1", op, in_ready);
      end
      if (track) sb_q.push_back(model(op, x, y));
      @(posedge clock); #1;
      in_valid = 1'b0;
      opcode = 4'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; opcode = 4'h4; a = 32'h1; b = 32'h2;
      repeat (3) @(posedge clock);
      #1;
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL reset_ctrl in_ready,out_valid=%b required=10", {in_ready, out_valid});
      end
      checks++;
      if (obs !== res_t'(0)) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", obs);
      end
      clear_n = 1'b1;
      @(posedge clock); #1;
   endtask

   vec_t sc_vec [16] = '{
      '{4'h4, 32'h7FFF_FFFF, 32'h0000_0001}, '{4'h4, 32'hFFFF_FFFF, 32'h0000_0001},
      '{4'h5, 32'h0000_0005, 32'h0000_0007}, '{4'h5, 32'h8000_0000, 32'h0000_0001},
      '{4'h0, 32'hF0F0_A5A5, 32'hFF00_FF00}, '{4'h1, 32'hF0F0_A5A5, 32'h0F00_0F00},
      '{4'h2, 32'h1234_5678, 32'h1234_5678}, '{4'h3, 32'hFFFF_FFFF, 32'h0000_0000},
      '{4'h9, 32'h0000_0001, 32'h0000_001F}, '{4'hA, 32'h8000_0000, 32'h0000_0021},
      '{4'hB, 32'h8000_0000, 32'h0000_0004}, '{4'hC, 32'h8000_0001, 32'h0000_0001},
      '{4'hD, 32'h1234_5678, 32'h0000_0000}, '{4'hB, 32'h7000_0000, 32'h0000_0003},
      '{4'hE, 32'h0000_0005, 32'h0000_0005}, '{4'hF, 32'hDEAD_BEEF, 32'h0000_0001}
   };

   task automatic test_single_cycle();
      res_t e;
      int   lat;
      for (int i = 0; i < 16; i++) begin
         issue(sc_vec[i].op, sc_vec[i].a, sc_vec[i].b, 1'b1);
         lat = 1;
         while (!out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
         e = sb_q.pop_front();
         checks++;
         if (!out_valid || obs !== e) begin
            failures++;
            $display("FAIL sc_result[%0d] op=%h got=%h required=%h valid=%b", i, sc_vec[i].op, obs, e, out_valid);
         end
         checks++;
         if (lat != 1) begin
            failures++;
            $display("FAIL sc_latency[%0d] got=%0d required=1", i, lat);
         end
      end
   endtask

   vec_t md_vec [10] = '{
      '{4'h6, 32'hFFFF_FFFD, 32'h0000_0007}, '{4'h7, 32'hFFFF_FFF9, 32'h0000_0002},
      '{4'h8, 32'hFFFF_FFF9, 32'h0000_0002}, '{4'h7, 32'h0000_0007, 32'h0000_0000},
      '{4'h7, 32'h8000_0000, 32'hFFFF_FFFF}, '{4'h6, 32'h8000_0000, 32'h8000_0000},
      '{4'h6, 32'h1234_5678, 32'h0000_0000}, '{4'h7, 32'h0000_0007, 32'hFFFF_FFFE},
      '{4'h8, 32'h0000_0005, 32'h0000_0007}, '{4'h8, 32'hFFFF_FFF8, 32'h0000_0000}
   };

   task automatic test_muldiv();
      res_t e;
      int   lat;
      bit   busy_ok;
      for (int i = 0; i < 10; i++) begin
         issue(md_vec[i].op, md_vec[i].a, md_vec[i].b, 1'b1);
         lat = 1; busy_ok = 1'b1;
         while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clock); #1; lat++;
         end
         e = sb_q.pop_front();
         checks++;
         if (!out_valid || obs !== e) begin
            failures++;
            $display("FAIL md_result[%0d] op=%h got=%h required=%h valid=%b", i, md_vec[i].op, obs, e, out_valid);
         end
         checks++;
         if (lat != exp_lat(md_vec[i].op, md_vec[i].b) || !busy_ok) begin
            failures++;
            $display("FAIL md_latency[%0d] got=%0d required=%0d in_ready_low_while_busy=%b",
                     i, lat, exp_lat(md_vec[i].op, md_vec[i].b), busy_ok);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t e, e2;
      @(posedge clock); #1;
      out_ready = 1'b0;
      issue(4'hD, 32'h1, 32'h1, 1'b1);
      e = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, e}) begin
            failures++;
            $display("FAIL hold[%0d] valid,ready=%b%b got=%h required=%h", k, out_valid, in_ready, obs, e);
         end
         @(posedge clock); #1;
      end
      opcode = 4'h5; a = 32'd10; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
      e2 = model(4'h5, 32'd10, 32'd3);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b required=1", in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if (!out_valid || obs !== e2) begin
         failures++;
         $display("FAIL b2b_result got=%h required=%h valid=%b", obs, e2, out_valid);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid_mul();
      bit   seen = 1'b0;
      res_t e;
      int   lat;
      issue(4'h6, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
      repeat (9) @(posedge clock);
      #1;
      clear_n = 1'b0;
      @(posedge clock); #1;
      checks++;
      if ({in_ready, out_valid, obs} !== {1'b1, 1'b0, res_t'(0)}) begin
         failures++;
         $display("FAIL abort_state ready,valid=%b%b got=%h required=10 and 0", in_ready, out_valid, obs);
      end
      clear_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL abort_no_result out_valid seen=%b required=0", seen);
      end
      issue(4'h4, 32'd40, 32'd2, 1'b1);
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
      e = sb_q.pop_front();
      checks++;
      if (!out_valid || obs !== e || lat != 1) begin
         failures++;
         $display("FAIL after_abort got=%h required=%h latency=%0d", obs, e, lat);
      end
   endtask

   task automatic test_random();
      res_t         e;
      int           lat;
      logic [3:0]   op;
      logic [W-1:0] x, y;
      for (int i = 0; i < 24; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = $urandom;
         y  = (i % 6 == 5) ? '0 : (i % 2 == 0 ? $urandom : W'($urandom_range(1, 40)));
         issue(op, x, y, 1'b1);
         lat = 1;
         while (!out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
         e = sb_q.pop_front();
         checks++;
         if (!out_valid || obs !== e || lat != exp_lat(op, y)) begin
            failures++;
            $display("FAIL rand[%0d] op=%h a=%h b=%h got=%h required=%h latency=%0d/%0d",
                     i, op, x, y, obs, e, lat, exp_lat(op, y));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_cycle();
      test_muldiv();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
